// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: hex glyphs (active-high)
// and the slot state encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;
    localparam logic [6:0] SEG_A = 7'h77;
    localparam logic [6:0] SEG_B = 7'h7C;
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_E = 7'h79;
    localparam logic [6:0] SEG_F = 7'h71;

    // Active-low "all segments dark" pin value.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic {
        DEAD  = 1'b0,
        DRIVE = 1'b1
    } slot_t;

endpackage

// File: rtl/seg7scan_if.sv
// Display data bundle between the time-keeping logic (master) and the scanner (slave).
interface seg7scan_if #(
    parameter int NDIG = 4
) ();
    logic [4*NDIG-1:0] DIN;
    logic [NDIG-1:0]   DPIN;
    logic              LOAD;
    logic              LZB;
    logic [NDIG-1:0]   BLINK;
    logic [6:0]        nSEG;
    logic              nDP;
    logic [NDIG-1:0]   nDIGIT;

    modport master (
        output DIN, DPIN, LOAD, LZB, BLINK,
        input  nSEG, nDP, nDIGIT
    );

    modport slave (
        input  DIN, DPIN, LOAD, LZB, BLINK,
        output nSEG, nDP, nDIGIT
    );
endinterface

// File: rtl/hex7seg.sv
// Hex nibble to active-low gfedcba segment decoder.
module hex7seg
    import seg7_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg_n
);
    logic [6:0] pat;

    always_comb begin
        pat = SEG_0;
        case (nib)
            4'h0: pat = SEG_0;
            4'h1: pat = SEG_1;
            4'h2: pat = SEG_2;
            4'h3: pat = SEG_3;
            4'h4: pat = SEG_4;
            4'h5: pat = SEG_5;
            4'h6: pat = SEG_6;
            4'h7: pat = SEG_7;
            4'h8: pat = SEG_8;
            4'h9: pat = SEG_9;
            4'hA: pat = SEG_A;
            4'hB: pat = SEG_B;
            4'hC: pat = SEG_C;
            4'hD: pat = SEG_D;
            4'hE: pat = SEG_E;
            4'hF: pat = SEG_F;
        endcase
    end

    assign seg_n = ~pat;
endmodule

// File: rtl/seg7scan.sv
// Time-multiplexed common-anode 7-segment driver with dead-time, leading-zero
// blanking and per-digit blink.
//
//   state | meaning
//   DEAD  | prescaler < DEADT, every digit and segment dark (anti-ghosting gap)
//   DRIVE | prescaler >= DEADT, digit at the scan index is lit unless blanked
module seg7scan
    import seg7_pkg::*;
#(
    parameter int NDIG    = 4,
    parameter int SCANDIV = 50000,
    parameter int DEADT   = 500,
    parameter int BLINKFR = 125
) (
    input  logic       CLK,
    input  logic       nRST,
    seg7scan_if.slave  bus
);
    localparam int PW = (SCANDIV > 1) ? $clog2(SCANDIV) : 1;
    localparam int IW = (NDIG > 1)    ? $clog2(NDIG)    : 1;
    localparam int FW = (BLINKFR > 1) ? $clog2(BLINKFR) : 1;

    logic [PW-1:0]     psc;
    logic [IW-1:0]     idx;
    logic [FW-1:0]     fcnt;
    logic              phase;
    logic [4*NDIG-1:0] sh_din;
    logic [NDIG-1:0]   sh_dp;

    slot_t             state;
    logic [3:0]        nib;
    logic [6:0]        seg_n;
    logic [NDIG-1:0]   lzmask;
    logic              allz;
    logic              blank;
    logic [NDIG-1:0]   dig_sel;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            psc   <= '0;
            idx   <= '0;
            fcnt  <= '0;
            phase <= 1'b0;
        end else if (psc == PW'(SCANDIV - 1)) begin
            psc <= '0;
            if (idx == IW'(NDIG - 1)) begin
                idx <= '0;
                if (fcnt == FW'(BLINKFR - 1)) begin
                    fcnt  <= '0;
                    phase <= ~phase;
                end else begin
                    fcnt <= fcnt + FW'(1);
                end
            end else begin
                idx <= idx + IW'(1);
            end
        end else begin
            psc <= psc + PW'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sh_din <= '0;
            sh_dp  <= '0;
        end else if (bus.LOAD) begin
            sh_din <= bus.DIN;
            sh_dp  <= bus.DPIN;
        end
    end

    assign state = (psc < PW'(DEADT)) ? DEAD : DRIVE;

    // A digit is a leading zero when it and every more significant nibble are zero.
    always_comb begin
        lzmask = '0;
        allz   = 1'b1;
        for (int i = NDIG - 1; i >= 1; i--) begin
            allz      = allz && (sh_din[4*i +: 4] == 4'h0);
            lzmask[i] = allz;
        end
    end

    assign nib     = sh_din[int'(idx)*4 +: 4];
    assign blank   = (bus.LZB && lzmask[idx]) || (bus.BLINK[idx] && phase);
    assign dig_sel = NDIG'(1) << idx;

    hex7seg u_hex7seg (
        .nib   (nib),
        .seg_n (seg_n)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            bus.nSEG   <= SEG_OFF;
            bus.nDP    <= 1'b1;
            bus.nDIGIT <= '1;
        end else if (state == DEAD || blank) begin
            bus.nSEG   <= SEG_OFF;
            bus.nDP    <= 1'b1;
            bus.nDIGIT <= '1;
        end else begin
            bus.nSEG   <= seg_n;
            bus.nDP    <= ~sh_dp[idx];
            bus.nDIGIT <= ~dig_sel;
        end
    end
endmodule

// File: tb/tb_seg7scan.sv
// Self-checking bench for seg7scan: per-cycle comparison against an arithmetic
// model of scan position, blink phase, blanking and the shadow register.
module tb_seg7scan;
    localparam int NDIG    = 4;
    localparam int SCANDIV = 8;
    localparam int DEADT   = 2;
    localparam int BLINKFR = 2;

    logic clk;
    logic nrst;

    seg7scan_if #(.NDIG(NDIG)) bus ();

    seg7scan #(
        .NDIG    (NDIG),
        .SCANDIV (SCANDIV),
        .DEADT   (DEADT),
        .BLINKFR (BLINKFR)
    ) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;
    logic [15:0] mdin   = '0;
    logic [3:0]  mdp    = '0;
    logic [11:0] expv;

    logic [6:0] segtab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Expected pins after edge k, derived from elapsed cycles since reset release.
    function automatic logic [11:0] model(int unsigned k, logic [15:0] d, logic [3:0] dp,
                                          logic lzb, logic [3:0] bl);
        int unsigned pos, dg, ph;
        logic        blank;
        logic [3:0]  nb;
        logic [3:0]  onehot;
        pos   = k % SCANDIV;
        dg    = (k / SCANDIV) % NDIG;
        ph    = ((k / (SCANDIV * NDIG)) / BLINKFR) % 2;
        blank = (lzb && dg >= 1 && (d >> (4 * dg)) == 16'h0) || (bl[dg] && ph == 1);
        if (pos < DEADT || blank) return {7'h7F, 1'b1, 4'hF};
        nb     = d[4*dg +: 4];
        onehot = 4'b0001 << dg;
        return {~segtab[nb], ~dp[dg], ~onehot};
    endfunction

    function automatic logic [11:0] pins();
        return {bus.nSEG, bus.nDP, bus.nDIGIT};
    endfunction

    task automatic tick();
        logic        ld;
        logic [15:0] nd;
        logic [3:0]  ndp;
        expv = model(cyc, mdin, mdp, bus.LZB, bus.BLINK);
        ld   = bus.LOAD;
        nd   = bus.DIN;
        ndp  = bus.DPIN;
        @(posedge clk);
        if (ld && nrst) begin
            mdin = nd;
            mdp  = ndp;
        end
        cyc++;
        #1;
    endtask

    task automatic apply_reset();
        nrst     = 1'b0;
        bus.LOAD = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        nrst = 1'b1;
        cyc  = 0;
        mdin = '0;
        mdp  = '0;
    endtask

    task automatic test_reset();
        bus.DIN = 16'hFFFF; bus.DPIN = 4'hF; bus.LZB = 1'b0; bus.BLINK = '0;
        nrst = 1'b0;
        bus.LOAD = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (pins() !== {7'h7F, 1'b1, 4'hF}) begin
            errors++;
            $display("FAIL reset_hold got %h want %h", pins(), {7'h7F, 1'b1, 4'hF});
        end
        bus.LOAD = 1'b0;
        #2;
        nrst = 1'b1;
        cyc = 0; mdin = '0; mdp = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (pins() !== expv) begin
                errors++;
                $display("FAIL reset_release k=%0d got %h want %h", i, pins(), expv);
            end
            if (i == 2) begin
                checks++;
                if (bus.nSEG !== 7'h40 || bus.nDIGIT !== 4'b1110) begin
                    errors++;
                    $display("FAIL reset_first_drive got seg %h dig %b want 40 1110", bus.nSEG, bus.nDIGIT);
                end
            end
        end
    endtask

    task automatic test_scan();
        apply_reset();
        bus.DIN = 16'h1234; bus.DPIN = 4'b0010; bus.LOAD = 1'b1;
        for (int i = 0; i < 2 * SCANDIV * NDIG; i++) begin
            tick();
            bus.LOAD = 1'b0;
            checks++;
            if (pins() !== expv) begin
                errors++;
                $display("FAIL scan k=%0d got %h want %h", i, pins(), expv);
            end
            if (i == 10) begin
                checks++;
                if (bus.nSEG !== 7'h30 || bus.nDIGIT !== 4'b1101 || bus.nDP !== 1'b0) begin
                    errors++;
                    $display("FAIL scan_digit1 got %h/%b/%b want 30/1101/0", bus.nSEG, bus.nDIGIT, bus.nDP);
                end
            end
            if (i == 26) begin
                checks++;
                if (bus.nSEG !== 7'h79 || bus.nDIGIT !== 4'b0111) begin
                    errors++;
                    $display("FAIL scan_digit3 got %h/%b want 79/0111", bus.nSEG, bus.nDIGIT);
                end
            end
        end
    endtask

    task automatic test_lzb();
        apply_reset();
        bus.DIN = 16'h0070; bus.DPIN = 4'b0000; bus.LOAD = 1'b1; bus.LZB = 1'b1;
        for (int i = 0; i < 2 * SCANDIV * NDIG; i++) begin
            tick();
            bus.LOAD = 1'b0;
            checks++;
            if (pins() !== expv) begin
                errors++;
                $display("FAIL lzb k=%0d lzb=%0b got %h want %h", i, bus.LZB, pins(), expv);
            end
            if (i == 20) begin
                checks++;
                if (bus.nDIGIT !== 4'hF) begin
                    errors++;
                    $display("FAIL lzb_digit2_blank got %b want 1111", bus.nDIGIT);
                end
            end
            if (i == SCANDIV * NDIG - 1) bus.LZB = 1'b0;
            if (i == 58) begin
                checks++;
                if (bus.nSEG !== 7'h40 || bus.nDIGIT !== 4'b0111) begin
                    errors++;
                    $display("FAIL lzb_off_digit3 got %h/%b want 40/0111", bus.nSEG, bus.nDIGIT);
                end
            end
        end
    endtask

    task automatic test_blink();
        apply_reset();
        bus.DIN = 16'hFFFF; bus.DPIN = 4'b0000; bus.LOAD = 1'b1; bus.BLINK = 4'b0001;
        for (int i = 0; i < 6 * SCANDIV * NDIG; i++) begin
            tick();
            bus.LOAD = 1'b0;
            checks++;
            if (pins() !== expv) begin
                errors++;
                $display("FAIL blink k=%0d got %h want %h", i, pins(), expv);
            end
            if (i == 66 || i == 130) begin
                checks++;
                if (bus.nDIGIT !== ((i == 66) ? 4'hF : 4'b1110)) begin
                    errors++;
                    $display("FAIL blink_digit0 k=%0d got %b", i, bus.nDIGIT);
                end
            end
        end
        bus.BLINK = '0;
    endtask

    task automatic test_midload();
        apply_reset();
        bus.DIN = 16'h0008; bus.DPIN = 4'b0000;
        for (int i = 0; i < SCANDIV + 4; i++) begin
            bus.LOAD = (i == 4);
            tick();
            checks++;
            if (pins() !== expv) begin
                errors++;
                $display("FAIL midload k=%0d got %h want %h", i, pins(), expv);
            end
            if (i == 4 || i == 5) begin
                checks++;
                if (bus.nSEG !== ((i == 4) ? 7'h40 : 7'h00)) begin
                    errors++;
                    $display("FAIL midload_edge k=%0d got %h", i, bus.nSEG);
                end
            end
        end
        bus.LOAD = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        bus.DIN = 16'h1234; bus.DPIN = 4'b1111; bus.LOAD = 1'b1;
        for (int i = 0; i <= 21; i++) begin
            tick();
            bus.LOAD = 1'b0;
            checks++;
            if (pins() !== expv) begin
                errors++;
                $display("FAIL pre_reset k=%0d got %h want %h", i, pins(), expv);
            end
        end
        nrst = 1'b0;
        #1;
        checks++;
        if (pins() !== {7'h7F, 1'b1, 4'hF}) begin
            errors++;
            $display("FAIL async_reset got %h want %h", pins(), {7'h7F, 1'b1, 4'hF});
        end
        @(posedge clk);
        #3;
        nrst = 1'b1;
        cyc = 0; mdin = '0; mdp = '0;
        for (int i = 0; i < SCANDIV; i++) begin
            tick();
            checks++;
            if (pins() !== expv) begin
                errors++;
                $display("FAIL post_reset k=%0d got %h want %h", i, pins(), expv);
            end
        end
        checks++;
        if (bus.nSEG !== 7'h40 || bus.nDIGIT !== 4'b1110 || bus.nDP !== 1'b1) begin
            errors++;
            $display("FAIL shadow_cleared got %h/%b/%b want 40/1110/1", bus.nSEG, bus.nDIGIT, bus.nDP);
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        apply_reset();
        for (int i = 0; i < 800; i++) begin
            bus.LOAD = ($urandom_range(0, 5) == 0);
            if (bus.LOAD) begin
                d = 16'($urandom());
                for (int n = 0; n < NDIG; n++)
                    if ($urandom_range(0, 2) == 0) d[4*n +: 4] = 4'h0;
                bus.DIN  = d;
                bus.DPIN = 4'($urandom());
            end
            if ($urandom_range(0, 15) == 0) bus.LZB = ~bus.LZB;
            if ($urandom_range(0, 31) == 0) bus.BLINK = 4'($urandom());
            tick();
            checks++;
            if (pins() !== expv) begin
                errors++;
                $display("FAIL random k=%0d got %h want %h", i, pins(), expv);
            end
        end
        bus.LOAD = 1'b0;
    endtask

    initial begin
        nrst = 1'b0;
        bus.DIN = '0; bus.DPIN = '0; bus.LOAD = 1'b0; bus.LZB = 1'b0; bus.BLINK = '0;
        test_reset();
        test_scan();
        test_lzb();
        test_blink();
        test_midload();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
